spi_ctrl_dev_link: RTL and testbench
====================================

Name: spi_ctrl_dev_link

Overview:
Self-contained SPI link with a controller (master) and a peripheral device (slave) sharing one system clock, plus SPI pins exposed for observation. A rising edge on trigger_out makes the controller send a 32-bit word to the device. A falling edge on the active-low gpio_trigger makes the controller read a 32-bit word from the device and present it with a one-cycle ready pulse. The block is used as a bring-up/loopback harness for SPI firmware and RTL.

Parameters:
DATA_W, 32, frame width in bits.
CLK_DIV, 8, system clocks per SCLK half-period; minimum 4.

Ports:
clk  in  1  system clock (100 MHz nominal); all logic on rising edge.
rst  in  1  synchronous, active-high reset.
trigger_out  in  1  level input; rising edge requests a write transaction.
gpio_trigger  in  1  active-low; idle 1; falling edge requests a read transaction.
to_device  in  DATA_W  word the controller sends; sampled at transaction start.
to_controller  in  DATA_W  word the device returns; sampled by device at CS falling.
from_device  out  DATA_W  last word read by the controller.
from_device_rdy  out  1  one-cycle pulse when from_device updates.
spi_clk  out  1  SCLK, CPOL=0.
spi_mosi  out  1  controller-to-device data.
spi_miso  out  1  device-to-controller data.
spi_cs  out  1  active-low chip select.
dev_rx_data  out  DATA_W  last word received by the device.
dev_rx_valid  out  1  one-cycle pulse when dev_rx_data updates.

Behaviour:
- Reset values: spi_cs=1, spi_clk=0, spi_mosi=0, spi_miso=0, from_device=0, from_device_rdy=0, dev_rx_data=0, dev_rx_valid=0, both pending flags clear, FSM in IDLE.
- Reset asserted mid-transfer aborts the transfer immediately and restores the reset values. No ready or valid pulse is generated for the aborted frame.
- SPI mode 0, MSB first, exactly DATA_W SCLK periods per frame.
- Edge detection: registered copies of trigger_out and gpio_trigger. A rising edge of trigger_out sets pend_wr. A falling edge of gpio_trigger sets pend_rd.
- Edges that arrive while busy are latched in the pending flags. Holding a level produces exactly one request.
- Controller FSM:
  - IDLE: if pend_wr is set, start a write; otherwise if pend_rd is set, start a read. Write wins when both are pending. At start, clear the serviced flag, latch to_device into the TX shift register, latch the transaction type, drive spi_cs=0, and put the MSB on spi_mosi.
  - SETUP: wait CLK_DIV cycles.
  - XFER: toggle spi_clk every CLK_DIV cycles.
    - On each SCLK rise, shift spi_miso into the RX shift register.
    - On each SCLK fall, except after the last bit, put the next MOSI bit out.
    - Leave XFER after the DATA_W-th falling edge.
  - HOLD: wait CLK_DIV cycles, then drive spi_cs=1 and spi_mosi=0.
  - GAP: wait CLK_DIV cycles, then go to IDLE.
  - On entry to GAP after a read, load from_device from the RX register and pulse from_device_rdy for one cycle. After a write, from_device is unchanged and the captured MISO data is discarded.
- Device:
  - Synchronizes spi_clk, spi_cs and spi_mosi with two flops each and detects edges in the clk domain.
  - On CS falling: load to_controller into its shift register, drive its MSB on spi_miso, and clear the bit counter.
  - On synced SCLK rising: shift in mosi.
  - On synced SCLK falling: shift out the next MISO bit.
  - On CS rising with exactly DATA_W bits received: for a write transaction only, load dev_rx_data and pulse dev_rx_valid for one cycle.
    - Transaction type is passed to the device as an internal signal sampled at CS falling.
    - Frames with a wrong bit count are discarded.
  - spi_miso is 0 while spi_cs=1.
- CLK_DIV>=4 guarantees MISO is settled before the controller samples it despite the synchronizer latency.
- Frame duration with CLK_DIV=8 is (2*DATA_W+3)*CLK_DIV = 536 cycles (5.36 us), well under one 17 us trigger window.

Test Plan:
- Write: rst pulse, to_device=A5A5A5A5, trigger_out 0->1 and held for 17 us -> exactly one CS-low window with 32 SCLK rising edges; MOSI samples at rises 1,0,1,0,0,1,0,1,...; dev_rx_data=A5A5A5A5 with one dev_rx_valid pulse; from_device_rdy stays 0.
- Read: to_controller=5A5A5A5A, gpio_trigger 1->0 and held for 17 us -> one frame; from_device=5A5A5A5A with a single from_device_rdy pulse; dev_rx_valid stays 0.
- Level hold: trigger_out held high for 3 frame times -> no second transaction; releasing it and raising it again produces a new frame.
- Simultaneous requests: trigger_out rises and gpio_trigger falls in the same cycle -> write frame first, then a read frame after the GAP; both outputs are correct.
- Request while busy: gpio_trigger falls mid-write -> read runs immediately after the write's GAP.
- Reset mid-transfer: rst asserted at bit 10 -> spi_cs=1 and spi_clk=0 on the next cycle; no rdy or valid pulse; the next trigger produces a clean full frame.

Source files
------------

// File: rtl/spi_ctrl_dev_link.sv
// rtl/spi_ctrl_dev_link.sv - SPI controller and device loopback link on one system clock
module spi_ctrl_dev_link #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger_out,
  input  logic              gpio_trigger,
  input  logic [DATA_W-1:0] to_device,
  input  logic [DATA_W-1:0] to_controller,
  output logic [DATA_W-1:0] from_device,
  output logic              from_device_rdy,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_cs,
  output logic [DATA_W-1:0] dev_rx_data,
  output logic              dev_rx_valid
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
  state_t state, state_nxt;

  logic              trig_q, gpio_q, pend_wr, pend_rd;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              is_rd;
  logic              tick, last_bit, wr_edge, rd_edge, start_wr, start_rd;

  // device-side signals
  logic [2:0]        sclk_s, cs_s;
  logic [1:0]        mosi_s;
  logic              dev_wr, miso_q;
  logic [DATA_W-1:0] dev_tx, dev_rx_sr;
  logic [CNT_W-1:0]  dev_bits;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign wr_edge  = trigger_out & ~trig_q;
  assign rd_edge  = gpio_q & ~gpio_trigger;
  assign start_wr = (state == IDLE) & pend_wr;
  assign start_rd = (state == IDLE) & ~pend_wr & pend_rd;

  // Trigger edge detection; edges are remembered until the FSM services them
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q  <= 1'b0;
      gpio_q  <= 1'b1;
      pend_wr <= 1'b0;
      pend_rd <= 1'b0;
    end else begin
      trig_q  <= trigger_out;
      gpio_q  <= gpio_trigger;
      pend_wr <= (pend_wr & ~start_wr) | wr_edge;
      pend_rd <= (pend_rd & ~start_rd) | rd_edge;
    end
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Controller next-state logic; XFER ends on the last SCLK falling edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_wr || pend_rd) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = XFER;
      XFER:    if (tick && spi_clk && last_bit) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = GAP;
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controller datapath: divider, shift registers and SPI pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt         <= '0;
      bit_cnt         <= '0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      is_rd           <= 1'b0;
      spi_clk         <= 1'b0;
      spi_mosi        <= 1'b0;
      spi_cs          <= 1'b1;
      from_device     <= '0;
      from_device_rdy <= 1'b0;
    end else begin
      from_device_rdy <= 1'b0;
      div_cnt         <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: if (start_wr || start_rd) begin
          tx_sr    <= to_device;
          is_rd    <= start_rd;
          spi_cs   <= 1'b0;
          spi_mosi <= to_device[DATA_W-1];
          bit_cnt  <= '0;
        end
        XFER: if (tick) begin
          spi_clk <= ~spi_clk;
          if (!spi_clk) begin
            rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            if (!last_bit) begin
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
              spi_mosi <= tx_sr[DATA_W-2];
            end
          end
        end
        HOLD: if (tick) begin
          spi_cs   <= 1'b1;
          spi_mosi <= 1'b0;
          if (is_rd) begin
            from_device     <= rx_sr;
            from_device_rdy <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];

  // Device: synchronise the SPI pins, then shift on detected SCLK/CS edges
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s       <= '0;
      cs_s         <= '1;
      mosi_s       <= '0;
      dev_wr       <= 1'b0;
      miso_q       <= 1'b0;
      dev_tx       <= '0;
      dev_rx_sr    <= '0;
      dev_bits     <= '0;
      dev_rx_data  <= '0;
      dev_rx_valid <= 1'b0;
    end else begin
      sclk_s       <= {sclk_s[1:0], spi_clk};
      cs_s         <= {cs_s[1:0], spi_cs};
      mosi_s       <= {mosi_s[0], spi_mosi};
      dev_rx_valid <= 1'b0;
      if (cs_fall) begin
        dev_tx   <= to_controller;
        miso_q   <= to_controller[DATA_W-1];
        dev_bits <= '0;
        dev_wr   <= ~is_rd;
      end else if (cs_rise) begin
        miso_q <= 1'b0;
        if (dev_wr && dev_bits == CNT_W'(DATA_W)) begin
          dev_rx_data  <= dev_rx_sr;
          dev_rx_valid <= 1'b1;
        end
      end else if (!cs_s[1]) begin
        if (sclk_rise) begin
          dev_rx_sr <= {dev_rx_sr[DATA_W-2:0], mosi_s[1]};
          dev_bits  <= dev_bits + 1'b1;
        end
        if (sclk_fall) begin
          dev_tx <= {dev_tx[DATA_W-2:0], 1'b0};
          miso_q <= dev_tx[DATA_W-2];
        end
      end
    end
  end

  // MISO is released to 0 the moment chip select deasserts
  assign spi_miso = miso_q & ~spi_cs;

endmodule

// File: tb/tb_spi_ctrl_dev_link.sv
// tb/tb_spi_ctrl_dev_link.sv - testbench for spi_ctrl_dev_link
`timescale 1ns/1ps
module tb_spi_ctrl_dev_link;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger_out = 1'b0;
  logic        gpio_trigger = 1'b1;
  logic [31:0] to_device = '0;
  logic [31:0] to_controller = '0;
  logic [31:0] from_device;
  logic        from_device_rdy;
  logic        spi_clk, spi_mosi, spi_miso, spi_cs;
  logic [31:0] dev_rx_data;
  logic        dev_rx_valid;

  spi_ctrl_dev_link #(.DATA_W(32), .CLK_DIV(8)) dut (
    .clk(clk), .rst(rst),
    .trigger_out(trigger_out), .gpio_trigger(gpio_trigger),
    .to_device(to_device), .to_controller(to_controller),
    .from_device(from_device), .from_device_rdy(from_device_rdy),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs),
    .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          rd;
    int          rd_delay;
    int          hold;
    logic [31:0] td;
    logic [31:0] tc;
    logic [31:0] exp_devrx;
    logic [31:0] exp_from;
  } vec_t;

  typedef struct {
    int          rises;
    logic [31:0] mosi;
    logic [31:0] miso;
  } frame_t;

  typedef struct {
    bit          is_rdy;
    logic [31:0] data;
  } ev_t;

  int vectors = 0;
  int miscompares = 0;

  frame_t frames_q[$];
  ev_t    ev_q[$];
  bit     in_frame = 0;
  bit     prev_sclk = 0;
  int     mon_rises = 0;
  int     miso_viol = 0;
  logic [31:0] mon_mosi, mon_miso;

  // Pin-level monitor: decode frames from SPI pins and log output pulses
  always @(negedge clk) begin
    if (!spi_cs) begin
      if (!in_frame) begin
        in_frame  = 1;
        mon_rises = 0;
        mon_mosi  = '0;
        mon_miso  = '0;
      end
      if (spi_clk && !prev_sclk) begin
        mon_rises++;
        mon_mosi = {mon_mosi[30:0], spi_mosi};
        mon_miso = {mon_miso[30:0], spi_miso};
      end
    end else if (in_frame) begin
      in_frame = 0;
      frames_q.push_back('{mon_rises, mon_mosi, mon_miso});
    end
    if (spi_cs && spi_miso) miso_viol++;
    if (dev_rx_valid) ev_q.push_back('{1'b0, dev_rx_data});
    if (from_device_rdy) ev_q.push_back('{1'b1, from_device});
    prev_sclk = spi_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Applies one request pattern, waits for the link to go quiet, and checks
  // frames and output pulses against the transaction-level expectation.
  task automatic run_trial(input vec_t v, input string tag);
    ev_t exp_ev[$];
    int  nexp;
    int  cyc;
    frames_q.delete();
    ev_q.delete();
    to_device     = v.td;
    to_controller = v.tc;
    for (int c = 0; c <= v.rd_delay + v.hold; c++) begin
      trigger_out  = v.wr && (c < v.hold);
      gpio_trigger = !(v.rd && c >= v.rd_delay && c < v.rd_delay + v.hold);
      step();
    end
    trigger_out  = 1'b0;
    gpio_trigger = 1'b1;
    nexp = int'(v.wr) + int'(v.rd);
    cyc  = 0;
    while ((frames_q.size() < nexp || in_frame) && cyc < 6000) begin
      step();
      cyc++;
    end
    if (cyc >= 6000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: got %0d frames expected %0d", tag, frames_q.size(), nexp);
    end
    repeat (100) step();

    if (v.wr) exp_ev.push_back('{1'b0, v.td});
    if (v.rd) exp_ev.push_back('{1'b1, v.tc});

    chk({tag, " frames"}, 32'(frames_q.size()), 32'(nexp));
    for (int i = 0; i < frames_q.size() && i < nexp; i++) begin
      chk({tag, " rises"}, 32'(frames_q[i].rises), 32'd32);
      chk({tag, " mosi"}, frames_q[i].mosi, v.td);
      chk({tag, " miso"}, frames_q[i].miso, v.tc);
    end
    chk({tag, " events"}, 32'(ev_q.size()), 32'(exp_ev.size()));
    for (int i = 0; i < ev_q.size() && i < exp_ev.size(); i++) begin
      chk({tag, " ev_kind"}, 32'(ev_q[i].is_rdy), 32'(exp_ev[i].is_rdy));
      chk({tag, " ev_data"}, ev_q[i].data, exp_ev[i].data);
    end
    chk({tag, " from_device"}, from_device, v.exp_from);
    chk({tag, " dev_rx_data"}, dev_rx_data, v.exp_devrx);
    chk({tag, " cs_idle"}, 32'(spi_cs), 32'd1);
  endtask

  vec_t        tbl[$];
  logic [31:0] m_from, m_devrx;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{1, 0, 0,   1700, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 32'h00000000});
    tbl.push_back('{0, 1, 0,   1700, 32'h00000000, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A});
    tbl.push_back('{1, 0, 0,   1700, 32'h12345678, 32'h00000000, 32'h12345678, 32'h5A5A5A5A});
    tbl.push_back('{1, 0, 0,   4,    32'hCAFEF00D, 32'h11111111, 32'hCAFEF00D, 32'h5A5A5A5A});
    tbl.push_back('{1, 1, 0,   20,   32'h0F0F1234, 32'hDEADBEEF, 32'h0F0F1234, 32'hDEADBEEF});
    tbl.push_back('{1, 1, 180, 20,   32'hFFFF0000, 32'h00000001, 32'hFFFF0000, 32'h00000001});
    tbl.push_back('{0, 1, 0,   2,    32'h80000001, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF});
    tbl.push_back('{1, 0, 0,   2,    32'h00000000, 32'h80000001, 32'h00000000, 32'hFFFFFFFF});

    repeat (5) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst spi_cs", 32'(spi_cs), 32'd1);
    chk("rst spi_clk", 32'(spi_clk), 32'd0);
    chk("rst spi_mosi", 32'(spi_mosi), 32'd0);
    chk("rst spi_miso", 32'(spi_miso), 32'd0);
    chk("rst from_device", from_device, 32'd0);
    chk("rst from_device_rdy", 32'(from_device_rdy), 32'd0);
    chk("rst dev_rx_data", dev_rx_data, 32'd0);
    chk("rst dev_rx_valid", 32'(dev_rx_valid), 32'd0);
    step();

    for (int i = 0; i < tbl.size(); i++) run_trial(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a write at bit 10
    frames_q.delete();
    ev_q.delete();
    to_device   = 32'h13579BDF;
    trigger_out = 1'b1;
    repeat (3) step();
    trigger_out = 1'b0;
    begin
      int cyc = 0;
      while (!(in_frame && mon_rises >= 10) && cyc < 2000) begin
        step();
        cyc++;
      end
      chk("abort reached bit10", 32'(in_frame && mon_rises >= 10), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort spi_cs", 32'(spi_cs), 32'd1);
    chk("abort spi_clk", 32'(spi_clk), 32'd0);
    chk("abort spi_mosi", 32'(spi_mosi), 32'd0);
    step();
    rst = 1'b0;
    repeat (100) step();
    chk("abort events", 32'(ev_q.size()), 32'd0);
    chk("abort dev_rx_data", dev_rx_data, 32'd0);
    chk("abort from_device", from_device, 32'd0);
    run_trial('{1, 0, 0, 10, 32'h2468ACE0, 32'h3C3C3C3C, 32'h2468ACE0, 32'h00000000}, "post_abort");

    // Randomised request patterns against the transaction-level model
    m_from  = 32'h0;
    m_devrx = 32'h2468ACE0;
    for (int n = 0; n < 12; n++) begin
      vec_t v;
      v.wr       = 1'($urandom_range(0, 1));
      v.rd       = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.rd_delay = v.wr ? int'($urandom_range(0, 700)) : 0;
      v.hold     = int'($urandom_range(1, 900));
      v.td       = $urandom;
      v.tc       = $urandom;
      if (v.wr) m_devrx = v.td;
      if (v.rd) m_from  = v.tc;
      v.exp_devrx = m_devrx;
      v.exp_from  = m_from;
      run_trial(v, $sformatf("rnd%0d", n));
    end

    chk("miso while cs high", 32'(miso_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
